// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: instruction size,
// the queue entry layout and the credit/occupancy counter width.
package fetch_pkg;

  localparam int ILEN_BYTES = 4;

  // Queue entry for the default 32-bit configuration: PC and instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Counters must hold the value DEPTH itself, hence one bit above log2.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch unit bus: request/response channel to instruction memory, the
// redirect input and the instruction channel towards decode.
interface fetch_queue_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [AWIDTH-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DWIDTH-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [AWIDTH-1:0] redirect_pc;
  logic              insn_valid;
  logic              insn_ready;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, insn_valid, pc_o, insn_o,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, insn_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req_valid, imem_req_addr, insn_valid, pc_o, insn_o,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, insn_ready
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO of an arbitrary packed type with a flush input.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output T              head
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer and occupancy update; flush discards everything, including a
  // same-cycle pop which has already been consumed by the reader.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; validity is tracked by count,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential PC generator with outstanding
// request credit, in-order response capture into a queue, and redirect
// with flush and discard of in-flight responses.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int                DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] rsp_pc;
  logic [AWIDTH-1:0] redirect_aligned;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     drop_nxt;
  logic [CW-1:0]     count;
  logic              credit_ok;
  logic              req_fire;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;

  assign redirect_aligned = {bus.redirect_pc[AWIDTH-1:2], 2'b00};

  // Requests in flight plus queued entries never exceed the queue size,
  // so every response has a free slot waiting for it.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH);

  assign bus.imem_req_valid = rst && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response is kept only when nothing older is pending discard and no
  // redirect is flushing the queue this cycle.
  assign push      = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;
  assign push_data = '{pc: rsp_pc, insn: bus.imem_rsp_data};

  assign bus.insn_valid = rst && (count != '0);
  assign pop            = bus.insn_valid && bus.insn_ready;
  assign bus.pc_o       = bus.insn_valid ? head.pc   : '0;
  assign bus.insn_o     = bus.insn_valid ? head.insn : '0;

  // Credit and discard bookkeeping; a redirect marks everything still in
  // flight after this cycle's response for discard.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    drop_nxt        = drop;
    if (bus.imem_rsp_valid && (drop != '0)) drop_nxt = drop - 1'b1;
    if (bus.redirect_valid)                 drop_nxt = outstanding_nxt;
  end

  // PC, credit and discard state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= BASEADDR;
      rsp_pc      <= BASEADDR;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + AWIDTH'(ILEN_BYTES);
        if (push)     rsp_pc   <= rsp_pc + AWIDTH'(ILEN_BYTES);
      end
    end
  end

  sync_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a latency-configurable memory model and
// a transaction-level reference (epoch-style keep flags on in-flight
// requests, a queue of expected instructions, an expected next fetch PC).
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h01000000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          keep;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_queue_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  fetch_queue #(
    .DWIDTH   (32),
    .AWIDTH   (32),
    .BASEADDR (BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  int           lat      = 1;
  int           n_fire   = 0;
  int           n_coinc  = 0;
  pend_t        pend[$];
  fetch_entry_t mq[$];
  logic [31:0]  popped[$];
  logic [31:0]  exp_pc   = BASE;
  logic         saw_valid;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // One clock cycle: drive at the falling edge, compare against the
  // reference, then advance the reference to the post-edge state.
  task automatic step(input logic rdr, input logic [31:0] rpc,
                      input logic rq_rdy, input logic in_rdy);
    logic  rsp_now;
    logic  exp_rv;
    logic  fire;
    pend_t e;
    @(negedge clk);
    cyc++;
    rsp_now = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rq_rdy;
    bus.insn_ready     = in_rdy;
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(pend[0].addr) : $urandom;
    #1;
    check("insn_valid", 64'(bus.insn_valid), 64'(mq.size() != 0));
    check("pc_o",   64'(bus.pc_o),   64'((mq.size() != 0) ? mq[0].pc   : 32'h0));
    check("insn_o", 64'(bus.insn_o), 64'((mq.size() != 0) ? mq[0].insn : 32'h0));
    exp_rv = !rdr && ((pend.size() + mq.size()) < DEPTH);
    check("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    if (bus.imem_req_valid) check("req_addr", 64'(bus.imem_req_addr), 64'(exp_pc));
    saw_valid = bus.insn_valid;
    fire = bus.imem_req_valid && rq_rdy;
    if (rdr && rsp_now && (mq.size() != 0) && in_rdy) n_coinc++;
    if ((mq.size() != 0) && in_rdy) popped.push_back(mq.pop_front().pc);
    if (rsp_now) begin
      e = pend.pop_front();
      if (e.keep && !rdr) mq.push_back('{pc: e.addr, insn: mem_word(e.addr)});
    end
    if (rdr) begin
      mq.delete();
      foreach (pend[i]) pend[i].keep = 1'b0;
      exp_pc = {rpc[31:2], 2'b00};
    end else if (fire) begin
      pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat, keep: 1'b1});
      exp_pc = exp_pc + 32'd4;
      n_fire++;
    end
  endtask

  // Synchronous reset of DUT and memory for n cycles; outputs must be idle.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.insn_ready     = 1'b0;
      #1;
      check("rst_req_valid",  64'(bus.imem_req_valid), 64'(0));
      check("rst_insn_valid", 64'(bus.insn_valid),     64'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    pend.delete();
    mq.delete();
    exp_pc = BASE;
  endtask

  initial begin
    int pops;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.insn_ready     = 1'b0;
    do_reset(2);

    // Streaming with 1-cycle memory: one instruction per cycle after fill.
    lat = 1;
    popped.delete();
    for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("stream_pops", 64'(popped.size() >= 21), 64'(1));
    check("stream_pc0", 64'(popped[0]), 64'(32'h01000000));
    check("stream_pc1", 64'(popped[1]), 64'(32'h01000004));

    // Decode stalled: exactly DEPTH requests accepted, then issue stops.
    do_reset(1);
    n_fire = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("stall_fires", 64'(n_fire), 64'(DEPTH));
    check("stall_req_valid", 64'(bus.imem_req_valid), 64'(0));
    popped.delete();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("stall_drain_pc3", 64'(popped[3]), 64'(32'h0100000C));
    check("stall_resume", 64'(n_fire > DEPTH), 64'(1));

    // Memory not ready: address held at reset PC.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      check("hold_addr", 64'(bus.imem_req_addr), 64'(BASE));
    end

    // 3-cycle memory, 3 outstanding, redirect: in-flight responses dropped.
    do_reset(1);
    lat = 3;
    for (int i = 0; i < 20 && pend.size() < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("three_outstanding", 64'(pend.size()), 64'(3));
    step(1'b1, 32'h01000103, 1'b1, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 20 && !saw_valid; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("redir_seen", 64'(saw_valid), 64'(1));
    check("redir_first_pc", 64'(bus.pc_o), 64'(32'h01000100));

    // Redirect coinciding with an arriving response and a pop.
    do_reset(1);
    lat = 1;
    n_coinc = 0;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h00002000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("redir_rsp_pop_seen", 64'(n_coinc > 0), 64'(1));

    // Wrap from the top word to zero.
    step(1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
    popped.delete();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("wrap_pops", 64'(popped.size() >= 2), 64'(1));
    if (popped.size() >= 2) begin
      check("wrap_pc0", 64'(popped[0]), 64'(32'hFFFFFFFC));
      check("wrap_pc1", 64'(popped[1]), 64'(32'h00000000));
    end

    // Reset in the middle of a stream.
    do_reset(1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("midrst_insn_valid", 64'(bus.insn_valid), 64'(0));
    check("midrst_addr", 64'(bus.imem_req_addr), 64'(BASE));

    // Randomized traffic across latencies and handshake densities.
    pops = 0;
    for (int blk = 0; blk < 15; blk++) begin
      int p_rq, p_in, p_rd;
      lat  = $urandom_range(4, 1);
      p_rq = $urandom_range(100, 30);
      p_in = $urandom_range(100, 20);
      p_rd = $urandom_range(8, 0);
      for (int i = 0; i < 200; i++) begin
        logic        rd;
        logic [31:0] rpc;
        rd  = ($urandom_range(99, 0) < p_rd);
        rpc = ($urandom_range(9, 0) == 0) ? 32'hFFFFFFF8 | $urandom_range(7, 0) : $urandom;
        step(rd, rpc, $urandom_range(99, 0) < p_rq, $urandom_range(99, 0) < p_in);
      end
      pops += popped.size();
      popped.delete();
    end
    check("random_progress", 64'(pops > 500), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
